// File: rtl/note_lane_dropper.sv
// Single-lane falling-note engine: spawns NOTE_COUNT notes, judges each as hit (Good/Perfect) or miss.
// Define NOTE_KEY_EDGE_EN to make the lane key count only on the frame it is first pressed.
module note_lane_dropper #(
    parameter int unsigned X_START     = 160,
    parameter int unsigned Y_START     = 100,
    parameter int unsigned Y_MAX       = 400,
    parameter int unsigned SPRITE_H    = 40,
    parameter int unsigned HIT_LO      = 340,
    parameter int unsigned PERFECT_LO  = 360,
    parameter int unsigned PERFECT_HI  = 380,
    parameter logic [7:0]  LANE_KEY    = 8'h07,
    parameter logic [7:0]  START_KEY   = 8'h2C,
    parameter logic [7:0]  RESTART_KEY = 8'h01,
    parameter int unsigned DELAY       = 2740,
    parameter int unsigned GAP         = 60,
    parameter int unsigned SPEED       = 1,
    parameter int unsigned NOTE_COUNT  = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [7:0] keycode_second,
    output logic [9:0] drop_x,
    output logic [9:0] drop_y,
    output logic       visible,
    output logic       hit_pulse,
    output logic       perfect_pulse,
    output logic       miss_pulse,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FALL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  dropY_q, dropY_d;
    logic        visible_q, visible_d;
    logic        hitPulse_q, hitPulse_d;
    logic        perfectPulse_q, perfectPulse_d;
    logic        missPulse_q, missPulse_d;
    logic [7:0]  hitCount_q, hitCount_d;
    logic [7:0]  missCount_q, missCount_d;
    logic [7:0]  noteIdx_q, noteIdx_d;
    logic [11:0] frameCnt_q, frameCnt_d;
    logic        done_q, done_d;

    logic        startPressed, restartPressed, laneLevel, laneKey;
    logic [10:0] bottom;
    logic        atMiss, inWindow, inPerfect, judgeMiss, judgeHit, lastNote, waitDone;
    logic [11:0] waitLimit;
    logic [12:0] cntInc;

    assign startPressed   = (keycode == START_KEY)   || (keycode_second == START_KEY);
    assign restartPressed = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);
    assign laneLevel      = (keycode == LANE_KEY)    || (keycode_second == LANE_KEY);

`ifdef NOTE_KEY_EDGE_EN
    logic lanePrev_q;

    always_ff @(posedge frame_clk) begin
        if (Reset) lanePrev_q <= 1'b0;
        else       lanePrev_q <= laneLevel;
    end

    assign laneKey = laneLevel & ~lanePrev_q;
`else
    assign laneKey = laneLevel;
`endif

    // Bottom edge is compared one bit wider so a note near 1023 cannot wrap back into the window.
    assign bottom    = {1'b0, dropY_q} + 11'(SPRITE_H);
    assign atMiss    = bottom >= 11'(Y_MAX);
    assign inWindow  = bottom >= 11'(HIT_LO);
    assign inPerfect = (bottom >= 11'(PERFECT_LO)) && (bottom < 11'(PERFECT_HI));
    assign judgeMiss = (state_q == S_FALL) && atMiss;
    assign judgeHit  = (state_q == S_FALL) && !atMiss && laneKey && inWindow;
    assign lastNote  = noteIdx_q == 8'(NOTE_COUNT - 1);
    assign waitLimit = (noteIdx_q == 8'd0) ? 12'(DELAY) : 12'(GAP);
    assign cntInc    = {1'b0, frameCnt_q} + 13'd1;
    assign waitDone  = cntInc >= {1'b0, waitLimit};

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            dropY_q        <= 10'(Y_START);
            visible_q      <= 1'b0;
            hitPulse_q     <= 1'b0;
            perfectPulse_q <= 1'b0;
            missPulse_q    <= 1'b0;
            hitCount_q     <= 8'd0;
            missCount_q    <= 8'd0;
            noteIdx_q      <= 8'd0;
            frameCnt_q     <= 12'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dropY_q        <= dropY_d;
            visible_q      <= visible_d;
            hitPulse_q     <= hitPulse_d;
            perfectPulse_q <= perfectPulse_d;
            missPulse_q    <= missPulse_d;
            hitCount_q     <= hitCount_d;
            missCount_q    <= missCount_d;
            noteIdx_q      <= noteIdx_d;
            frameCnt_q     <= frameCnt_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (startPressed) state_d = S_WAIT;
            S_WAIT: if (waitDone) state_d = S_FALL;
            S_FALL: if (judgeMiss || judgeHit) state_d = lastNote ? S_DONE : S_WAIT;
            S_DONE: if (restartPressed) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values; pulses default low so each lasts exactly one frame.
    always_comb begin
        dropY_d        = dropY_q;
        visible_d      = visible_q;
        hitPulse_d     = 1'b0;
        perfectPulse_d = 1'b0;
        missPulse_d    = 1'b0;
        hitCount_d     = hitCount_q;
        missCount_d    = missCount_q;
        noteIdx_d      = noteIdx_q;
        frameCnt_d     = frameCnt_q;
        done_d         = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (startPressed) begin
                    hitCount_d  = 8'd0;
                    missCount_d = 8'd0;
                    noteIdx_d   = 8'd0;
                    frameCnt_d  = 12'd0;
                end
            end
            S_WAIT: begin
                frameCnt_d = cntInc[11:0];
                if (waitDone) begin
                    dropY_d    = 10'(Y_START);
                    visible_d  = 1'b1;
                    frameCnt_d = 12'd0;
                end
            end
            S_FALL: begin
                if (judgeMiss) begin
                    missPulse_d = 1'b1;
                    missCount_d = (missCount_q == 8'hFF) ? missCount_q : missCount_q + 8'd1;
                    visible_d   = 1'b0;
                end else if (judgeHit) begin
                    hitPulse_d     = 1'b1;
                    perfectPulse_d = inPerfect;
                    hitCount_d     = (hitCount_q == 8'hFF) ? hitCount_q : hitCount_q + 8'd1;
                    visible_d      = 1'b0;
                end else begin
                    dropY_d = dropY_q + 10'(SPEED);
                end
                if ((judgeMiss || judgeHit) && !lastNote) begin
                    noteIdx_d  = noteIdx_q + 8'd1;
                    frameCnt_d = 12'd0;
                end
            end
            S_DONE: visible_d = 1'b0;
            default: ;
        endcase
    end

    assign drop_x        = 10'(X_START);
    assign drop_y        = dropY_q;
    assign visible       = visible_q;
    assign hit_pulse     = hitPulse_q;
    assign perfect_pulse = perfectPulse_q;
    assign miss_pulse    = missPulse_q;
    assign hit_count     = hitCount_q;
    assign miss_count    = missCount_q;
    assign done          = done_q;

endmodule
